// File: rtl/tbec_pkg.sv
// Shared TBEC types, widths and codeword field offsets for the stream encoder.
// Imported by the lane core and by the top-level encoder.
package tbec_pkg;

   localparam int TBEC_DATA_W = 16;
   localparam int TBEC_CODE_W = 32;

   typedef logic [TBEC_DATA_W-1:0] tbec_data_t;
   typedef logic [TBEC_CODE_W-1:0] tbec_code_t;

   // Codeword layout: systematic bits on top, then DI, P and X check fields
   localparam int TBEC_SYS_MSB = 31;
   localparam int TBEC_SYS_LSB = 16;
   localparam int TBEC_DI_MSB  = 15;
   localparam int TBEC_DI_LSB  = 12;
   localparam int TBEC_P_MSB   = 11;
   localparam int TBEC_P_LSB   = 8;
   localparam int TBEC_X_MSB   = 7;
   localparam int TBEC_X_LSB   = 0;

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_FULL  = 2'd2
   } buf_state_t;

endpackage

// File: rtl/tbec_stream_encoder_lane_core.sv
// Combinational TBEC encode of one 16-bit lane into a 32-bit codeword.
// Nibble bit index 1 is the nibble MSB, index 4 the nibble LSB.
module tbec_lane_core
   import tbec_pkg::*;
(
   input  tbec_data_t data,
   output tbec_code_t code
);

   logic [3:0] a;
   logic [3:0] b;
   logic [3:0] c;
   logic [3:0] d;
   logic [3:0] di_field;
   logic [3:0] p_field;
   logic [7:0] x_field;
   logic [15:0] sys_field;

   assign a = data[15:12];
   assign b = data[11:8];
   assign c = data[7:4];
   assign d = data[3:0];

   // Systematic part interleaves the four nibbles bit-plane by bit-plane
   assign sys_field = {a[3], b[3], c[3], d[3],
                       a[2], b[2], c[2], d[2],
                       a[1], b[1], c[1], d[1],
                       a[0], b[0], c[0], d[0]};

   // Field order {DI1, DI4, DI2, DI3}
   assign di_field = {a[3] ^ b[2] ^ c[3] ^ d[2],
                      a[0] ^ b[1] ^ c[0] ^ d[1],
                      a[2] ^ b[3] ^ c[2] ^ d[3],
                      a[1] ^ b[0] ^ c[1] ^ d[0]};

   // Field order {P1, P4, P2, P3}
   assign p_field = {a[3] ^ a[2] ^ b[3] ^ b[2],
                     c[1] ^ c[0] ^ d[1] ^ d[0],
                     c[3] ^ c[2] ^ d[3] ^ d[2],
                     a[1] ^ a[0] ^ b[1] ^ b[0]};

   assign x_field = {a[3] ^ a[1], a[2] ^ a[0],
                     b[3] ^ b[1], b[2] ^ b[0],
                     c[3] ^ c[1], c[2] ^ c[0],
                     d[3] ^ d[1], d[2] ^ d[0]};

   always_comb begin
      code = '0;
      code[TBEC_SYS_MSB:TBEC_SYS_LSB] = sys_field;
      code[TBEC_DI_MSB:TBEC_DI_LSB]   = di_field;
      code[TBEC_P_MSB:TBEC_P_LSB]     = p_field;
      code[TBEC_X_MSB:TBEC_X_LSB]     = x_field;
   end

endmodule

// File: rtl/tbec_stream_encoder.sv
// Multi-lane streaming TBEC encoder with a 2-entry registered output buffer.
// Optional fault injection on pushed codewords when TBEC_ERR_INJ_EN is defined.
module tbec_stream_encoder
   import tbec_pkg::*;
#(
   parameter int LANES = 4,
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic [TBEC_DATA_W*LANES-1:0] s_data,
   input  logic [TAG_W-1:0]             s_tag,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [TBEC_CODE_W*LANES-1:0] m_code,
   output logic [TAG_W-1:0]             m_tag,
   output logic [CNT_W-1:0]             beat_cnt,
   input  logic                         clr_cnt
`ifdef TBEC_ERR_INJ_EN
   ,
   input  logic                         inj_en,
   input  logic [TBEC_CODE_W*LANES-1:0] inj_mask
`endif
);

   localparam int CODE_BUS_W = TBEC_CODE_W * LANES;

   logic [CODE_BUS_W-1:0] enc_code;
   logic [CODE_BUS_W-1:0] push_code;
   logic [CODE_BUS_W-1:0] spare_code;
   logic [TAG_W-1:0]      spare_tag;
   buf_state_t            state;
   logic                  push;
   logic                  pop;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      tbec_lane_core u_core (
         .data (s_data[TBEC_DATA_W*k +: TBEC_DATA_W]),
         .code (enc_code[TBEC_CODE_W*k +: TBEC_CODE_W])
      );
   end

`ifdef TBEC_ERR_INJ_EN
   assign push_code = inj_en ? (enc_code ^ inj_mask) : enc_code;
`else
   assign push_code = enc_code;
`endif

   // s_ready is a register, so no combinational path runs from m_ready
   assign push = s_valid & s_ready;
   assign pop  = m_valid & m_ready;

   // state     | meaning
   // BUF_EMPTY | no entry held, m_valid low
   // BUF_ONE   | head entry on m_code/m_tag
   // BUF_FULL  | head on m_code plus one spare entry, s_ready low
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= BUF_EMPTY;
         s_ready    <= 1'b0;
         m_valid    <= 1'b0;
         m_code     <= '0;
         m_tag      <= '0;
         spare_code <= '0;
         spare_tag  <= '0;
      end else begin
         case (state)
            BUF_EMPTY: begin
               s_ready <= 1'b1;
               if (push) begin
                  m_code  <= push_code;
                  m_tag   <= s_tag;
                  m_valid <= 1'b1;
                  state   <= BUF_ONE;
               end
            end
            BUF_ONE: begin
               s_ready <= 1'b1;
               if (push && pop) begin
                  m_code <= push_code;
                  m_tag  <= s_tag;
               end else if (push) begin
                  spare_code <= push_code;
                  spare_tag  <= s_tag;
                  s_ready    <= 1'b0;
                  state      <= BUF_FULL;
               end else if (pop) begin
                  m_valid <= 1'b0;
                  state   <= BUF_EMPTY;
               end
            end
            BUF_FULL: begin
               if (pop) begin
                  m_code  <= spare_code;
                  m_tag   <= spare_tag;
                  s_ready <= 1'b1;
                  state   <= BUF_ONE;
               end else begin
                  s_ready <= 1'b0;
               end
            end
            default: begin
               s_ready <= 1'b0;
               m_valid <= 1'b0;
               state   <= BUF_EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_cnt <= '0;
      end else if (clr_cnt) begin
         beat_cnt <= '0;
      end else if (pop) begin
         beat_cnt <= beat_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_tbec_stream_encoder.sv
// Directed bench for tbec_stream_encoder: encode table, backpressure,
// counter wrap/clear and asynchronous reset with a full buffer.
module tb_tbec_stream_encoder;

   localparam int LANES = 4;
   localparam int TAG_W = 4;
   localparam int CNT_W = 4;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                s_valid = 1'b0;
   logic                s_ready;
   logic [16*LANES-1:0] s_data = '0;
   logic [TAG_W-1:0]    s_tag = '0;
   logic                m_valid;
   logic                m_ready = 1'b1;
   logic [32*LANES-1:0] m_code;
   logic [TAG_W-1:0]    m_tag;
   logic [CNT_W-1:0]    beat_cnt;
   logic                clr_cnt = 1'b0;

   logic                d1_s_valid = 1'b0;
   logic                d1_s_ready;
   logic [15:0]         d1_s_data = '0;
   logic [3:0]          d1_s_tag = '0;
   logic                d1_m_valid;
   logic [31:0]         d1_m_code;
   logic [3:0]          d1_m_tag;
   logic [15:0]         d1_beat_cnt;

`ifdef TBEC_ERR_INJ_EN
   logic                inj_en = 1'b0;
   logic [32*LANES-1:0] inj_mask = '0;
`endif

   always #5 clk = ~clk;

   tbec_stream_encoder #(.LANES(LANES), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_data   (s_data),
      .s_tag    (s_tag),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_code   (m_code),
      .m_tag    (m_tag),
      .beat_cnt (beat_cnt),
      .clr_cnt  (clr_cnt)
`ifdef TBEC_ERR_INJ_EN
      ,
      .inj_en   (inj_en),
      .inj_mask (inj_mask)
`endif
   );

   tbec_stream_encoder #(.LANES(1), .TAG_W(4), .CNT_W(16)) dut1 (
      .clk      (clk),
      .rst      (rst),
      .s_valid  (d1_s_valid),
      .s_ready  (d1_s_ready),
      .s_data   (d1_s_data),
      .s_tag    (d1_s_tag),
      .m_valid  (d1_m_valid),
      .m_ready  (1'b1),
      .m_code   (d1_m_code),
      .m_tag    (d1_m_tag),
      .beat_cnt (d1_beat_cnt),
      .clr_cnt  (1'b0)
`ifdef TBEC_ERR_INJ_EN
      ,
      .inj_en   (1'b0),
      .inj_mask (32'h0)
`endif
   );

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [63:0]  data;
      logic [3:0]   tag;
      logic [127:0] code;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int i);
      s_valid = 1'b1;
      s_data  = vecs[i].data;
      s_tag   = vecs[i].tag;
   endtask

   initial begin
      vecs[0] = '{64'h8000_FFFF_0000_0001, 4'h1, 128'h8000_8880_FFFF_0000_0000_0000_0001_1401};
      vecs[1] = '{64'h1234_0800_00F0_FFFF, 4'h2, 128'h016A_D26D_4000_2820_2222_F000_FFFF_0000};
      vecs[2] = '{64'h0000_0000_0000_0000, 4'h3, 128'h0};
      vecs[3] = '{64'h0001_1234_8000_00F0, 4'h4, 128'h0001_1401_016A_D26D_8000_8880_2222_F000};
      vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 4'h5, 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000};
      vecs[5] = '{64'h0800_0001_1234_8000, 4'h6, 128'h4000_2820_0001_1401_016A_D26D_8000_8880};

      // reset state
      tick();
      tick();
      check("rst_m_valid", m_valid, 0);
      check("rst_s_ready", s_ready, 0);
      check("rst_m_code", m_code, 0);
      check("rst_m_tag", m_tag, 0);
      check("rst_beat_cnt", beat_cnt, 0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      check("post_rst_s_ready", s_ready, 1);
      check("post_rst_m_valid", m_valid, 0);

      // single lane, single beat
      d1_s_valid = 1'b1;
      d1_s_data  = 16'h0001;
      d1_s_tag   = 4'h9;
      tick();
      d1_s_valid = 1'b0;
      check("l1_m_valid", d1_m_valid, 1);
      check("l1_m_code", d1_m_code, 32'h0001_1401);
      check("l1_m_tag", d1_m_tag, 4'h9);
      tick();
      check("l1_beat_cnt", d1_beat_cnt, 1);
      check("l1_drained", d1_m_valid, 0);

      // table: back-to-back streaming, one beat per cycle
      for (int i = 0; i < 6; i++) begin
         drive(i);
         tick();
         check($sformatf("vec%0d_m_valid", i), m_valid, 1);
         check($sformatf("vec%0d_m_code", i), m_code, vecs[i].code);
         check($sformatf("vec%0d_m_tag", i), m_tag, vecs[i].tag);
         check($sformatf("vec%0d_s_ready", i), s_ready, 1);
      end
      s_valid = 1'b0;
      tick();
      check("stream_drained", m_valid, 0);
      check("stream_cnt", beat_cnt, 6);

      // backpressure: 2 beats accepted, third stalls
      m_ready = 1'b0;
      drive(0);
      tick();
      check("bp_b0_code", m_code, vecs[0].code);
      check("bp_ready_after1", s_ready, 1);
      drive(1);
      tick();
      check("bp_ready_after2", s_ready, 0);
      check("bp_hold_code", m_code, vecs[0].code);
      drive(2);
      tick();
      check("bp_still_full", s_ready, 0);
      check("bp_hold_code2", m_code, vecs[0].code);
      check("bp_hold_tag", m_tag, vecs[0].tag);
      m_ready = 1'b1;
      tick();
      check("bp_out1_code", m_code, vecs[1].code);
      check("bp_out1_tag", m_tag, vecs[1].tag);
      check("bp_ready_back", s_ready, 1);
      tick();
      check("bp_out2_code", m_code, vecs[2].code);
      check("bp_out2_tag", m_tag, vecs[2].tag);
      s_valid = 1'b0;
      tick();
      check("bp_drained", m_valid, 0);
      check("bp_cnt", beat_cnt, 9);

      // counter wrap: 6 more beats to 15, then one more to 0
      for (int i = 0; i < 6; i++) begin
         drive(i);
         tick();
      end
      s_valid = 1'b0;
      tick();
      check("cnt_all_ones", beat_cnt, 15);
      drive(3);
      tick();
      s_valid = 1'b0;
      tick();
      check("cnt_wrap", beat_cnt, 0);

      // clear takes priority over a simultaneous handshake
      drive(0);
      tick();
      drive(1);
      tick();
      s_valid = 1'b0;
      tick();
      check("cnt_two", beat_cnt, 2);
      drive(2);
      tick();
      s_valid = 1'b0;
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      check("cnt_clr_with_hs", beat_cnt, 0);
      check("clr_drained", m_valid, 0);
      drive(4);
      tick();
      s_valid = 1'b0;
      tick();
      check("cnt_after_clr", beat_cnt, 1);

      // asynchronous reset with a full buffer
      m_ready = 1'b0;
      drive(2);
      tick();
      drive(3);
      tick();
      s_valid = 1'b0;
      check("full_m_valid", m_valid, 1);
      check("full_s_ready", s_ready, 0);
      #2;
      rst = 1'b1;
      #1;
      check("async_m_valid", m_valid, 0);
      check("async_s_ready", s_ready, 0);
      check("async_m_code", m_code, 0);
      check("async_m_tag", m_tag, 0);
      check("async_cnt", beat_cnt, 0);
      @(negedge clk);
      rst = 1'b0;
      m_ready = 1'b1;
      tick();
      check("rel_s_ready", s_ready, 1);
      check("rel_empty", m_valid, 0);
      tick();
      check("rel_still_empty", m_valid, 0);
      drive(5);
      tick();
      s_valid = 1'b0;
      check("rel_beat_code", m_code, vecs[5].code);
      check("rel_beat_tag", m_tag, vecs[5].tag);
      tick();

`ifdef TBEC_ERR_INJ_EN
      s_valid  = 1'b1;
      s_data   = '0;
      s_tag    = 4'hA;
      inj_en   = 1'b1;
      inj_mask = 128'h4;
      tick();
      s_valid = 1'b0;
      inj_en  = 1'b0;
      check("inj_m_code", m_code, 128'h4);
      tick();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
